// File: rtl/cnn_pkg.sv
// Constants and window indexing shared by the window buffer and the convolution MAC stage.
package cnn_pkg;
  localparam int DATA_W     = 8;
  localparam int IMG_WIDTH  = 80;
  localparam int IMG_HEIGHT = 60;
  localparam int KERNEL     = 3;

  // Bit offset of element (r,c) inside a packed KERNELxKERNEL window.
  function automatic int idx(input int r, input int c);
    return (r * KERNEL + c) * DATA_W;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: shared address, combinational read-before-write, clocked write.
// Contents are never reset; consumers mask stale data by position.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH  = IMG_WIDTH,
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dat,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_dat = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_dat;
  end

endmodule

// File: rtl/pixel_window_buffer.sv
// Sliding 3x3 window over a raster pixel stream; window and win_valid appear 1 cycle after the pixel.
// No backpressure: one window per accepted pixel, the consumer must keep up.
module pixel_window_buffer
  import cnn_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pix_valid,
  input  logic [DATA_W-1:0]     pixel,
  output logic [9*DATA_W-1:0]   window,
  output logic                  win_valid,
  output logic                  done
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int WIN_W = KERNEL * KERNEL * DATA_W;

  logic [COL_W-1:0]  col_q, col_d, ptr_q, ptr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [WIN_W-1:0]  window_q, window_d;
  logic              win_valid_q, win_valid_d;
  logic              done_q, done_d;
  logic              accept;
  logic [DATA_W-1:0] lb1_rd, lb2_rd;

  assign accept = pix_valid && !start && !done_q;

  // lb1 holds the previous row; lb2 is fed from lb1's pre-write value and holds the row before that.
  line_buffer #(.DEPTH(WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb1 (
    .clk    (clk),
    .addr   (ptr_q),
    .wr_en  (accept),
    .wr_dat (pixel),
    .rd_dat (lb1_rd)
  );

  line_buffer #(.DEPTH(WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb2 (
    .clk    (clk),
    .addr   (ptr_q),
    .wr_en  (accept),
    .wr_dat (lb1_rd),
    .rd_dat (lb2_rd)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    ptr_d       = ptr_q;
    window_d    = window_q;
    win_valid_d = 1'b0;
    done_d      = done_q;
    if (start) begin
      col_d  = '0;
      row_d  = '0;
      ptr_d  = '0;
      done_d = 1'b0;
    end else if (accept) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) begin
          window_d[(r*KERNEL+c)*DATA_W +: DATA_W] = window_q[(r*KERNEL+c+1)*DATA_W +: DATA_W];
        end
      end
      window_d[(0*KERNEL+2)*DATA_W +: DATA_W] = lb2_rd;
      window_d[(1*KERNEL+2)*DATA_W +: DATA_W] = lb1_rd;
      window_d[(2*KERNEL+2)*DATA_W +: DATA_W] = pixel;
      // Columns 0/1 would mix the tail of the previous row into the window.
      win_valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      ptr_d = (ptr_q == COL_W'(WIDTH - 1)) ? '0 : ptr_q + COL_W'(1);
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_d = '0;
        if (row_q == ROW_W'(HEIGHT - 1)) begin
          row_d  = '0;
          done_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      ptr_q       <= '0;
      window_q    <= '0;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      ptr_q       <= ptr_d;
      window_q    <= window_d;
      win_valid_q <= win_valid_d;
      done_q      <= done_d;
    end
  end

  assign window    = window_q;
  assign win_valid = win_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pixel_window_buffer.sv
// Bench for pixel_window_buffer: a 4x4 instance driven from a vector table and corner sequences,
// and a default-size instance driven with random pixels against an image-array reference.
module tb_pixel_window_buffer;
  import cnn_pkg::*;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int BW = IMG_WIDTH;
  localparam int BH = IMG_HEIGHT;
  localparam int WB = 9 * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              s_start = 1'b0, s_pv = 1'b0;
  logic [DATA_W-1:0] s_px = '0;
  logic [WB-1:0]     s_win;
  logic              s_wv, s_done;

  logic              b_start = 1'b0, b_pv = 1'b0;
  logic [DATA_W-1:0] b_px = '0;
  logic [WB-1:0]     b_win;
  logic              b_wv, b_done;

  pixel_window_buffer #(.WIDTH(SW), .HEIGHT(SH), .DATA_W(DATA_W)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .pix_valid(s_pv), .pixel(s_px),
    .window(s_win), .win_valid(s_wv), .done(s_done)
  );

  pixel_window_buffer #(.WIDTH(BW), .HEIGHT(BH), .DATA_W(DATA_W)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .pix_valid(b_pv), .pixel(b_px),
    .window(b_win), .win_valid(b_wv), .done(b_done)
  );

  typedef struct packed {
    logic [DATA_W-1:0] px;
    logic              exp_wv;
    logic              exp_done;
    logic [WB-1:0]     exp_win;
  } vec_t;

  vec_t tab [16];
  int n_cmp = 0;
  int n_bad = 0;

  function void chk(input string name, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endfunction

  // Window whose top-left pixel value is base in a 4-wide frame of pixels numbered 1..16.
  function automatic logic [WB-1:0] mkwin(input int base);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[idx(r, c) +: DATA_W] = DATA_W'(base + r * SW + c);
    return w;
  endfunction

  task automatic step_s(input logic pv, input logic st, input logic [DATA_W-1:0] px);
    s_pv = pv; s_start = st; s_px = px;
    @(posedge clk); #1;
    s_pv = 1'b0; s_start = 1'b0;
  endtask

  task automatic run_table(input string tag, input int gaps);
    logic [WB-1:0] last;
    for (int i = 0; i < 16; i++) begin
      step_s(1'b1, 1'b0, tab[i].px);
      chk({tag, "_wv"}, WB'(s_wv), WB'(tab[i].exp_wv));
      chk({tag, "_done"}, WB'(s_done), WB'(tab[i].exp_done));
      if (tab[i].exp_wv) chk({tag, "_win"}, s_win, tab[i].exp_win);
      last = s_win;
      for (int g = 0; g < gaps; g++) begin
        step_s(1'b0, 1'b0, 8'hee);
        chk({tag, "_gap_wv"}, WB'(s_wv), '0);
        chk({tag, "_gap_win"}, s_win, last);
      end
    end
  endtask

  // Reference for the random run: pixels stored by raster position, windows read straight from the image.
  int           img [BW*BH];
  int           k = 0;
  logic         m_done = 1'b0;
  logic         e_wv;
  logic [WB-1:0] e_win;
  int           pulses = 0;
  int           cyc = 0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      tab[i].px = DATA_W'(i + 1);
      tab[i].exp_wv = 1'b0;
      tab[i].exp_done = 1'b0;
      tab[i].exp_win = '0;
    end
    tab[10].exp_wv = 1'b1; tab[10].exp_win = mkwin(1);
    tab[11].exp_wv = 1'b1; tab[11].exp_win = mkwin(2);
    tab[14].exp_wv = 1'b1; tab[14].exp_win = mkwin(5);
    tab[15].exp_wv = 1'b1; tab[15].exp_win = mkwin(6);
    tab[15].exp_done = 1'b1;

    #2;
    chk("rst_s_wv", WB'(s_wv), '0);
    chk("rst_s_done", WB'(s_done), '0);
    chk("rst_s_win", s_win, '0);
    chk("rst_b_wv", WB'(b_wv), '0);
    chk("rst_b_done", WB'(b_done), '0);
    chk("rst_b_win", b_win, '0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_table("frame", 0);

    begin
      logic [WB-1:0] held;
      held = s_win;
      for (int j = 0; j < 5; j++) begin
        step_s(1'b1, 1'b0, DATA_W'(200 + j));
        chk("postdone_wv", WB'(s_wv), '0);
        chk("postdone_win", s_win, held);
        chk("postdone_done", WB'(s_done), WB'(1));
      end
      step_s(1'b0, 1'b1, '0);
      chk("start_clr_done", WB'(s_done), '0);
      chk("start_keeps_win", s_win, held);
    end

    run_table("gaps", 2);
    step_s(1'b0, 1'b1, '0);

    for (int j = 1; j <= 9; j++) begin
      step_s(1'b1, 1'b0, DATA_W'(j));
      chk("midstart_pre_done", WB'(s_done), '0);
    end
    step_s(1'b1, 1'b1, 8'd99);
    chk("midstart_drop_wv", WB'(s_wv), '0);
    chk("midstart_drop_done", WB'(s_done), '0);
    run_table("midstart", 0);

    step_s(1'b0, 1'b1, '0);
    for (int j = 1; j <= 11; j++) step_s(1'b1, 1'b0, DATA_W'(j));
    chk("prereset_wv", WB'(s_wv), WB'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wv", WB'(s_wv), '0);
    chk("arst_done", WB'(s_done), '0);
    chk("arst_win", s_win, '0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_table("afterrst", 0);

    // Random full frame on the default-size instance, with random stalls.
    while (k < BW * BH && cyc < 20000) begin
      b_pv = ($urandom_range(3) != 0);
      b_px = DATA_W'($urandom);
      e_wv = 1'b0;
      if (b_pv && !m_done) begin
        img[k] = int'(b_px);
        e_wv = (k / BW >= 2) && (k % BW >= 2);
        if (e_wv) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              e_win[idx(r, c) +: DATA_W] = DATA_W'(img[(k / BW - 2 + r) * BW + (k % BW) - 2 + c]);
        end
        k++;
        if (k == BW * BH) m_done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (b_wv) pulses++;
      chk("rand_wv", WB'(b_wv), WB'(e_wv));
      chk("rand_done", WB'(b_done), WB'(m_done));
      if (e_wv) chk("rand_win", b_win, e_win);
    end
    chk("rand_all_pixels_sent", WB'(k), WB'(BW * BH));
    for (int j = 0; j < 3; j++) begin
      b_pv = 1'b1; b_px = DATA_W'($urandom);
      @(posedge clk); #1;
      if (b_wv) pulses++;
      chk("rand_postdone_wv", WB'(b_wv), '0);
      chk("rand_postdone_done", WB'(b_done), WB'(1));
    end
    b_pv = 1'b0;
    chk("rand_pulse_count", WB'(pulses), WB'((BW - 2) * (BH - 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
